mc_branch_sequencer: RTL and testbench
======================================

Name: mc_branch_sequencer

Overview:
- Sits directly downstream of one multicast route-compute (RC) lane.
- Each cycle, RC presents up to three routed branches, each a data word plus a 5-bit one-hot output direction.
- This block captures a branch set, then issues the branches one at a time to the switch-allocator request interface with a valid/grant handshake.
- It holds the RC ready input low until every branch of the captured set has been granted.

Parameters:
- DATASIZE, 30, flit width in bits.
- DIRW, 5, direction vector width. Bit order: 0 = Local, 1 = N, 2 = E, 3 = S, 4 = W.

Ports:
- mc_clk  input  1  block clock.
- rst  input  1  reset, asynchronous, active-high.
- data_in1, data_in2, data_in3  input  DATASIZE each  branch data from RC.
- direction_in1, direction_in2, direction_in3  input  DIRW each  branch direction. 0 means the branch is absent.
- rc_ready  output  1  drives the RC stage's rc_ready; high means a new branch set may be captured.
- req_valid  output  1  switch-allocator request valid.
- req_data  output  DATASIZE  data of the branch being requested.
- req_dir  output  DIRW  direction of the branch being requested.
- req_grant  input  1  allocator accepts the current request.
- err_dir  output  1  sticky; set when a captured direction has more than one bit set.

Behaviour:
- Reset (asynchronous assert): rc_ready=1, req_valid=0, req_data=0, req_dir=0, err_dir=0, all three slots cleared, state=IDLE. Reset asserted mid-operation discards every pending branch.
- Storage: three slots, each holding data, direction and a pend bit.
- State IDLE:
  - rc_ready=1, req_valid=0.
  - On a clock edge where any direction_inN is nonzero, load all three slots. pendN = |direction_inN.
  - Go to ISSUE. rc_ready=0 from the next cycle.
  - If all directions are 0, nothing is captured and the state stays IDLE.
- State ISSUE:
  - req_valid=1.
  - req_data/req_dir come from the lowest-index slot with pend=1 (priority 1 > 2 > 3).
  - When req_valid and req_grant are both high on an edge, that slot's pend clears. The next pending slot is presented the following cycle.
  - When the last pend clears, the next state is IDLE: req_valid=0 and rc_ready=1 the following cycle.
- Handshake rules:
  - Once req_valid is high, req_data and req_dir stay stable until grant.
  - req_valid never drops without a grant, except on reset.
  - req_grant while req_valid=0 is ignored.
- Latency:
  - Capture edge to first req_valid: 1 cycle.
  - Each granted branch advances in 1 cycle, so N branches with grant held high take N cycles.
  - Last grant to rc_ready high: 1 cycle. This gives one bubble cycle between branch sets.
- Ignored inputs: direction_in values arriving while rc_ready=0 are ignored.
- Error handling: a captured direction with popcount > 1 sets err_dir (cleared only by reset). That branch is still issued unchanged.
- All outputs are registered. There is no combinational path from req_grant to any output.

Optional Feature:
- Macro MC_BRANCH_MERGE_EN.
- Defined:
  - At capture, any later slot whose data equals an earlier pending slot's data has its direction ORed into the earlier slot, and its own pend is cleared.
  - The merged request carries a multi-hot req_dir, and one grant retires all merged directions.
  - err_dir is still evaluated on the raw inputs.
- Undefined: every pending slot is issued separately, exactly as in Behaviour.

Decomposition:
- Package mc_pkg holds:
  - Direction bit-index constants DIR_L, DIR_N, DIR_E, DIR_S, DIR_W.
  - DIRW.
  - State encoding (IDLE, ISSUE).
  - Constant NUM_BRANCH = 3.
- One sub-module, mc_branch_pick: combinational lowest-index pending selector returning the slot index and an any-pending flag. It is reused by the merge logic.

Test Plan:
- Directions (5'b00010, 0, 0), data 0x1234, grant held high -> one req with req_dir=5'b00010 and req_data=0x1234 one cycle after capture; rc_ready low 2 cycles, then high.
- Directions (N, E, W), datas A, B, C, grant high -> req_dir sequence 00010, 00100, 10000 on consecutive cycles; rc_ready high 1 cycle after the third grant.
- Same as previous, but grant low for 4 cycles on the first request -> req_data=A and req_dir=N held stable for all 4 cycles; sequence otherwise unchanged.
- All directions 0 while idle -> no capture; rc_ready stays 1, req_valid stays 0.
- Directions (5'b00110, S, 0) -> err_dir=1 and stays set; both branches are still issued. Reset asserted mid-ISSUE -> next cycle req_valid=0, rc_ready=1, err_dir=0.
- With MC_BRANCH_MERGE_EN: datas A, A, B with directions N, E, S -> two requests, (A, 5'b00110) then (B, 5'b01000).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants, state encoding and helpers for the multicast branch sequencer.
package mc_pkg;

  localparam int unsigned DIRW       = 5;
  localparam int unsigned DIR_L      = 0;
  localparam int unsigned DIR_N      = 1;
  localparam int unsigned DIR_E      = 2;
  localparam int unsigned DIR_S      = 3;
  localparam int unsigned DIR_W      = 4;
  localparam int unsigned NUM_BRANCH = 3;
  localparam int unsigned IDXW       = $clog2(NUM_BRANCH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // True when more than one direction bit is set.
  function automatic logic multi_hot(input logic [DIRW-1:0] d);
    return (d & (d - DIRW'(1))) != '0;
  endfunction

endpackage

// File: rtl/mc_branch_sequencer_if.sv
// Switch-allocator request handshake between the branch sequencer and the allocator.
interface mc_branch_sequencer_if #(
  parameter int unsigned DATASIZE = 30
) ();

  logic                     req_valid;
  logic [DATASIZE-1:0]      req_data;
  logic [mc_pkg::DIRW-1:0]  req_dir;
  logic                     req_grant;

  modport master (
    output req_valid,
    output req_data,
    output req_dir,
    input  req_grant
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_dir,
    output req_grant
  );

endinterface

// File: rtl/mc_branch_pick.sv
// Combinational lowest-index pending selector over the branch slots.
module mc_branch_pick
  import mc_pkg::*;
(
  input  logic [NUM_BRANCH-1:0] pend,
  output logic [IDXW-1:0]       idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_BRANCH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = IDXW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_branch_sequencer.sv
// Captures one multicast branch set from RC and issues its branches one at a time to the
// switch allocator. Define MC_BRANCH_MERGE_EN to fold same-data branches into one request.
module mc_branch_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned DATASIZE = 30
) (
  input  logic                mc_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in1,
  input  logic [DATASIZE-1:0] data_in2,
  input  logic [DATASIZE-1:0] data_in3,
  input  logic [DIRW-1:0]     direction_in1,
  input  logic [DIRW-1:0]     direction_in2,
  input  logic [DIRW-1:0]     direction_in3,
  output logic                rc_ready,
  output logic                err_dir,
  mc_branch_sequencer_if.master req
);

  state_e                state_q;
  logic [DATASIZE-1:0]   data_q [NUM_BRANCH];
  logic [DIRW-1:0]       dir_q  [NUM_BRANCH];
  logic [NUM_BRANCH-1:0] pend_q;

  logic [DATASIZE-1:0]   in_data [NUM_BRANCH];
  logic [DIRW-1:0]       in_dir  [NUM_BRANCH];
  logic [NUM_BRANCH-1:0] in_pend;
  logic                  in_multi;

  logic [DIRW-1:0]       cap_dir [NUM_BRANCH];
  logic [NUM_BRANCH-1:0] cap_pend;
  logic [IDXW-1:0]       cap_idx;
  logic                  cap_any;

  logic [IDXW-1:0]       cur_idx;
  logic                  cur_any;
  logic [NUM_BRANCH-1:0] cur_clr;
  logic [NUM_BRANCH-1:0] nxt_pend;
  logic [IDXW-1:0]       nxt_idx;
  logic                  nxt_any;

  assign in_data[0] = data_in1;
  assign in_data[1] = data_in2;
  assign in_data[2] = data_in3;
  assign in_dir[0]  = direction_in1;
  assign in_dir[1]  = direction_in2;
  assign in_dir[2]  = direction_in3;

  always_comb begin
    in_multi = 1'b0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      in_pend[i] = |in_dir[i];
      in_multi   = in_multi | multi_hot(in_dir[i]);
    end
  end

`ifdef MC_BRANCH_MERGE_EN
  logic [NUM_BRANCH-1:0][IDXW-1:0] merge_into;
  logic [NUM_BRANCH-1:0]           merge_hit;

  // Each slot folds into the lowest earlier pending slot carrying identical data.
  for (genvar j = 0; j < NUM_BRANCH; j++) begin : g_merge
    logic [NUM_BRANCH-1:0] match;
    always_comb begin
      match = '0;
      for (int i = 0; i < j; i++) begin
        match[i] = in_pend[i] && in_pend[j] && (in_data[i] == in_data[j]);
      end
    end
    mc_branch_pick u_merge_pick (
      .pend (match),
      .idx  (merge_into[j]),
      .any  (merge_hit[j])
    );
  end

  always_comb begin
    cap_dir  = in_dir;
    cap_pend = in_pend;
    for (int j = 0; j < NUM_BRANCH; j++) begin
      if (merge_hit[j]) begin
        cap_dir[merge_into[j]] = cap_dir[merge_into[j]] | in_dir[j];
        cap_pend[j]            = 1'b0;
      end
    end
  end
`else
  always_comb begin
    cap_dir  = in_dir;
    cap_pend = in_pend;
  end
`endif

  mc_branch_pick u_cap_pick (
    .pend (cap_pend),
    .idx  (cap_idx),
    .any  (cap_any)
  );

  mc_branch_pick u_cur_pick (
    .pend (pend_q),
    .idx  (cur_idx),
    .any  (cur_any)
  );

  always_comb begin
    cur_clr          = '0;
    cur_clr[cur_idx] = 1'b1;
  end

  assign nxt_pend = pend_q & ~cur_clr;

  mc_branch_pick u_nxt_pick (
    .pend (nxt_pend),
    .idx  (nxt_idx),
    .any  (nxt_any)
  );

  always_ff @(posedge mc_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '{default: '0};
      dir_q         <= '{default: '0};
      pend_q        <= '0;
      rc_ready      <= 1'b1;
      err_dir       <= 1'b0;
      req.req_valid <= 1'b0;
      req.req_data  <= '0;
      req.req_dir   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // rc_ready low here is the bubble cycle after the last grant.
          if (!rc_ready) begin
            rc_ready <= 1'b1;
          end else if (cap_any) begin
            data_q        <= in_data;
            dir_q         <= cap_dir;
            pend_q        <= cap_pend;
            err_dir       <= err_dir | in_multi;
            rc_ready      <= 1'b0;
            req.req_valid <= 1'b1;
            req.req_data  <= in_data[cap_idx];
            req.req_dir   <= cap_dir[cap_idx];
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (req.req_valid && req.req_grant && cur_any) begin
            pend_q <= nxt_pend;
            if (nxt_any) begin
              req.req_data <= data_q[nxt_idx];
              req.req_dir  <= dir_q[nxt_idx];
            end else begin
              req.req_valid <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_branch_sequencer.sv
// Self-checking bench for mc_branch_sequencer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mc_branch_sequencer;
  import mc_pkg::*;

  localparam int unsigned DATASIZE = 30;

  typedef struct {
    logic [DATASIZE-1:0] data;
    logic [DIRW-1:0]     dir;
  } req_t;

  typedef struct {
    logic [DIRW-1:0]     d1, d2, d3;
    logic [DATASIZE-1:0] a, b, c;
    logic                g;
    logic                ev;
    logic [DIRW-1:0]     edir;
    logic [DATASIZE-1:0] edata;
    logic                erc;
  } vec_t;

  localparam logic [DIRW-1:0] N = 5'b00010;
  localparam logic [DIRW-1:0] E = 5'b00100;
  localparam logic [DIRW-1:0] S = 5'b01000;
  localparam logic [DIRW-1:0] W = 5'b10000;
  localparam logic [DATASIZE-1:0] DA = 30'h0AAA_AAA;
  localparam logic [DATASIZE-1:0] DB = 30'h0BBB_BBB;
  localparam logic [DATASIZE-1:0] DC = 30'h0CCC_CCC;

  logic                mc_clk;
  logic                rst;
  logic [DATASIZE-1:0] data_in1, data_in2, data_in3;
  logic [DIRW-1:0]     direction_in1, direction_in2, direction_in3;
  logic                rc_ready;
  logic                err_dir;

  mc_branch_sequencer_if #(.DATASIZE(DATASIZE)) req_if ();

  mc_branch_sequencer #(.DATASIZE(DATASIZE)) dut (
    .mc_clk        (mc_clk),
    .rst           (rst),
    .data_in1      (data_in1),
    .data_in2      (data_in2),
    .data_in3      (data_in3),
    .direction_in1 (direction_in1),
    .direction_in2 (direction_in2),
    .direction_in3 (direction_in3),
    .rc_ready      (rc_ready),
    .err_dir       (err_dir),
    .req           (req_if.master)
  );

  initial mc_clk = 1'b0;
  always #5 mc_clk = ~mc_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  req_t mq[$];
  logic m_bubble = 1'b0;
  logic m_err    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a set becomes an ordered list of requests; one pops per grant, then one
  // idle bubble cycle before the next set may be accepted.
  task automatic model_edge();
    req_t                nl[$];
    logic [DIRW-1:0]     d[3];
    logic [DATASIZE-1:0] v[3];
    logic                found;
    d[0] = direction_in1; d[1] = direction_in2; d[2] = direction_in3;
    v[0] = data_in1;      v[1] = data_in2;      v[2] = data_in3;
    if (mq.size() > 0) begin
      if (req_if.req_grant) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_bubble = 1'b1;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (d[i] != '0) begin
          if ($countones(d[i]) > 1) m_err = 1'b1;
          found = 1'b0;
`ifdef MC_BRANCH_MERGE_EN
          for (int k = 0; k < nl.size(); k++) begin
            if (!found && nl[k].data == v[i]) begin
              nl[k].dir = nl[k].dir | d[i];
              found     = 1'b1;
            end
          end
`endif
          if (!found) nl.push_back('{data: v[i], dir: d[i]});
        end
      end
      mq = nl;
    end
  endtask

  task automatic step(input logic [DIRW-1:0] d1, input logic [DIRW-1:0] d2,
                      input logic [DIRW-1:0] d3, input logic [DATASIZE-1:0] a,
                      input logic [DATASIZE-1:0] b, input logic [DATASIZE-1:0] c,
                      input logic g);
    direction_in1 = d1; direction_in2 = d2; direction_in3 = d3;
    data_in1 = a; data_in2 = b; data_in3 = c;
    req_if.req_grant = g;
    @(posedge mc_clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic g);
    step('0, '0, '0, '0, '0, '0, g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    direction_in1 = '0; direction_in2 = '0; direction_in3 = '0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0;
    req_if.req_grant = 1'b0;
    @(posedge mc_clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_bubble = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic [DIRW-1:0] edir,
                           input logic [DATASIZE-1:0] edata);
    check({tag, "_valid"}, req_if.req_valid, 1);
    check({tag, "_dir"},   req_if.req_dir,   edir);
    check({tag, "_data"},  req_if.req_data,  edata);
  endtask

  vec_t vt[9];

  initial begin
    rst = 1'b1;
    req_if.req_grant = 1'b0;
    direction_in1 = '0; direction_in2 = '0; direction_in3 = '0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0;

    // d1 d2 d3 a b c g | ev edir edata erc ; rows 2,5,8 drive inputs that must be ignored
    vt[0] = '{'0, '0, '0, '0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1};
    vt[1] = '{N,  '0, '0, 30'h1234, '0, '0, 1'b1, 1'b1, N, 30'h1234, 1'b0};
    vt[2] = '{E,  '0, '0, 30'h55, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0};
    vt[3] = '{'0, '0, '0, '0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1};
    vt[4] = '{N,  E,  W,  DA, DB, DC, 1'b1, 1'b1, N, DA, 1'b0};
    vt[5] = '{S,  '0, '0, 30'h77, '0, '0, 1'b1, 1'b1, E, DB, 1'b0};
    vt[6] = '{'0, '0, '0, '0, '0, '0, 1'b1, 1'b1, W, DC, 1'b0};
    vt[7] = '{'0, '0, '0, '0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0};
    vt[8] = '{N,  '0, '0, 30'h99, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1};

    do_reset();
    check("reset_valid",    req_if.req_valid, 0);
    check("reset_rc_ready", rc_ready,         1);
    check("reset_err",      err_dir,          0);
    check("reset_data",     req_if.req_data,  0);
    check("reset_dir",      req_if.req_dir,   0);

    for (int i = 0; i < 9; i++) begin
      step(vt[i].d1, vt[i].d2, vt[i].d3, vt[i].a, vt[i].b, vt[i].c, vt[i].g);
      check($sformatf("vec%0d_valid", i), req_if.req_valid, vt[i].ev);
      check($sformatf("vec%0d_rc_ready", i), rc_ready, vt[i].erc);
      if (vt[i].ev) begin
        check($sformatf("vec%0d_dir", i),  req_if.req_dir,  vt[i].edir);
        check($sformatf("vec%0d_data", i), req_if.req_data, vt[i].edata);
      end
    end

    // Grant withheld on the first request: it must hold steady.
    step(N, E, W, DA, DB, DC, 1'b0);
    check_req("stall0", N, DA);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0);
      check_req($sformatf("stall%0d", i), N, DA);
    end
    idle(1'b1);
    check_req("stall_b", E, DB);
    idle(1'b1);
    check_req("stall_c", W, DC);
    idle(1'b1);
    check("stall_end_valid", req_if.req_valid, 0);
    check("stall_end_rc",    rc_ready,         0);
    idle(1'b0);
    check("stall_ready", rc_ready, 1);

    // Multi-hot direction flags err_dir but is issued as-is; then async reset mid-issue.
    step(5'b00110, S, '0, 30'h11, 30'h22, '0, 1'b0);
    check_req("err_first", 5'b00110, 30'h11);
    check("err_set", err_dir, 1);
    idle(1'b1);
    check_req("err_second", S, 30'h22);
    check("err_sticky", err_dir, 1);
    idle(1'b0);
    check_req("err_hold", S, 30'h22);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", req_if.req_valid, 0);
    check("arst_rc",    rc_ready,         1);
    check("arst_err",   err_dir,          0);
    @(posedge mc_clk);
    #1;
    check("rst_cycle_valid", req_if.req_valid, 0);
    check("rst_cycle_rc",    rc_ready,         1);
    rst = 1'b0;
    mq.delete();
    m_bubble = 1'b0;
    m_err    = 1'b0;
    idle(1'b1);
    check("post_rst_valid", req_if.req_valid, 0);

`ifdef MC_BRANCH_MERGE_EN
    step(N, E, S, DA, DA, DB, 1'b1);
    check_req("merge_a", 5'b00110, DA);
    idle(1'b1);
    check_req("merge_b", 5'b01000, DB);
    idle(1'b1);
    check("merge_end_valid", req_if.req_valid, 0);
`endif

    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [DIRW-1:0] rd[3];
      for (int i = 0; i < 3; i++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4)      rd[i] = '0;
        else if (r < 8) rd[i] = 5'b00001 << $urandom_range(0, 4);
        else            rd[i] = 5'($urandom_range(1, 31));
      end
      step(rd[0], rd[1], rd[2], 30'($urandom_range(1, 3)), 30'($urandom_range(1, 3)),
           30'($urandom_range(1, 3)), ($urandom_range(0, 9) < 7));
      check("rnd_valid",    req_if.req_valid, (mq.size() > 0));
      check("rnd_rc_ready", rc_ready,         (mq.size() == 0 && !m_bubble));
      check("rnd_err",      err_dir,          m_err);
      if (mq.size() > 0) begin
        check("rnd_dir",  req_if.req_dir,  mq[0].dir);
        check("rnd_data", req_if.req_data, mq[0].data);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
